mvb_rx_frame_ctrl: RTL and testbench
====================================

Name: mvb_rx_frame_ctrl

Overview:
- Receive-side sequencer for the MVB frame deserializer.
- Arms the deserializer on a start-delimiter detect and sizes the frame from a size selector.
- Forwards and indexes the 16-bit data words, folds CRC, quality and length checks into a single per-frame verdict, then parks the deserializer in reset between frames.
- Sits between the Manchester decoder / delimiter detector and the MVB receive buffer.

Parameters:
- CHECK_LAT, 3: cycles past expected frame end in which late crc_error pulses are still collected.
- SKIP_FIRST, 1: number of word_valid pulses after deserializer release that are discarded (startup word).
- TIMEOUT_CYC, 16: cycles past expected frame end without ed_detect before the frame is declared stuck.

Ports:
- clk_3M  in  1  3 MHz bit clock.
- rst  in  1  Synchronous reset, active-low.
- sd_detect  in  1  Start-delimiter detected, 1-cycle pulse.
- ed_detect  in  1  End-delimiter detected, 1-cycle pulse.
- size_sel  in  3  Frame data size: 0=16, 1=32, 2=64, 3=128, 4=256 bits; 5-7 illegal.
- word_valid  in  1  Deserializer word strobe, 1-cycle pulse.
- word_data  in  16  Deserializer parallel word.
- crc_error  in  1  Deserializer CRC mismatch pulse.
- quality_error  in  1  Manchester quality violation, level.
- des_rst_n  out  1  Deserializer synchronous reset, active-low.
- rx_word  out  16  Forwarded data word.
- rx_word_valid  out  1  Strobe for rx_word, 1 cycle.
- rx_word_idx  out  4  Index of rx_word within the frame, 0..15.
- frame_done  out  1  Good-frame pulse.
- frame_err  out  1  Bad-frame pulse.
- err_code  out  3  Error cause, held until next accepted sd_detect.
- busy  out  1  High while a frame is in progress.

Behaviour:
- Reset values (rst=0): state IDLE; des_rst_n=0; rx_word=0; rx_word_valid=0; rx_word_idx=0; frame_done=0; frame_err=0; err_code=0; busy=0; all internal counters 0.
- Size table, indexed by size_sel 0..4:
  - exp_bits (including CRC cells) = 24, 40, 72, 144, 288.
  - exp_words = 1, 2, 4, 8, 16.
- Bit counter is 9 bits; word counter is 5 bits.
- IDLE:
  - des_rst_n=0, busy=0.
  - sd_detect with legal size_sel: latch size, clear bit_cnt, word_cnt, skip_cnt and the sticky flags, set err_code=0, go RECV.
  - sd_detect with illegal size_sel: go ERR with err_code=5.
- RECV:
  - des_rst_n=1 from the first RECV cycle; busy=1; bit_cnt increments every cycle.
  - word_valid while skip_cnt<SKIP_FIRST: skip_cnt++, nothing forwarded.
  - Otherwise, if word_cnt<exp_words: next cycle rx_word=word_data, rx_word_idx=word_cnt[3:0], rx_word_valid=1, then word_cnt++.
  - Otherwise set sticky ovf (word dropped).
  - crc_error sets sticky crc_seen; quality_error sets sticky q_seen.
  - ed_detect with bit_cnt<exp_bits: go ERR with err_code=4 (short frame).
  - bit_cnt == exp_bits+CHECK_LAT: go CHECK.
  - If ed_detect has still not arrived at bit_cnt == exp_bits+TIMEOUT_CYC: go ERR with err_code=6. This only applies when TIMEOUT_CYC > CHECK_LAT; otherwise CHECK is reached first.
- CHECK (1 cycle): the first matching condition, in priority order, sets err_code and goes ERR; if none match, go DONE.
  - crc_seen: err_code=1.
  - q_seen: err_code=3.
  - word_cnt != exp_words or ovf: err_code=2.
- DONE (1 cycle): frame_done=1; go IDLE; des_rst_n=0 from the next cycle.
- ERR (1 cycle): frame_err=1; go IDLE; des_rst_n=0 from the next cycle.
- sd_detect outside IDLE is ignored.
- ed_detect at or after exp_bits is accepted silently.
- rst=0 mid-frame aborts immediately to reset values; no done/err pulse is issued.
- frame_done and frame_err are never high in the same cycle.

Optional Feature:
- Macro MVB_RX_STATS_EN.
- Defined:
  - Adds outputs good_cnt[15:0] and bad_cnt[15:0].
  - Incremented on frame_done and frame_err respectively.
  - Saturate at 16'hFFFF; cleared by rst.
- Undefined: both ports are absent; no counter logic is built.

Test Plan:
- size_sel=0, sd_detect, one discarded startup word, then word 16'hA5C3, no crc_error, ed at bit 24 -> rx_word_valid once with idx 0 / 16'hA5C3; frame_done at cycle 28 after RECV entry; err_code=0.
- size_sel=4, 17 word_valid pulses (first skipped) with data 0x0000..0x000F -> idx 0..15 in order; frame_done; with MVB_RX_STATS_EN, good_cnt=1.
- size_sel=2, crc_error pulse at bit_cnt 73 -> frame_err, err_code=1; des_rst_n low the next cycle.
- size_sel=1, ed_detect at bit 20 -> frame_err, err_code=4 the cycle after; no frame_done.
- size_sel=6 with sd_detect -> frame_err, err_code=5, busy never asserted.
- Mid-frame rst=0 at bit 50 of size_sel=3 -> all outputs at reset values the next cycle. A following sd_detect with size_sel=0 completes normally with frame_done.

Source files
------------

// File: rtl/mvb_rx_frame_ctrl.sv
// Receive-side frame sequencer for the MVB deserializer: arms it on a start delimiter, forwards and indexes words, and gives one verdict per frame.
// Optional MVB_RX_STATS_EN adds saturating good_cnt / bad_cnt frame counters.
`timescale 1ns/1ps
module mvb_rx_frame_ctrl #(
  parameter int CHECK_LAT   = 3,
  parameter int SKIP_FIRST  = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk_3M,
  input  logic        rst,
  input  logic        sd_detect,
  input  logic        ed_detect,
  input  logic [2:0]  size_sel,
  input  logic        word_valid,
  input  logic [15:0] word_data,
  input  logic        crc_error,
  input  logic        quality_error,
  output logic        des_rst_n,
  output logic [15:0] rx_word,
  output logic        rx_word_valid,
  output logic [3:0]  rx_word_idx,
  output logic        frame_done,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic        busy
`ifdef MVB_RX_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_CRC     = 3'd1;
  localparam logic [2:0] E_LEN     = 3'd2;
  localparam logic [2:0] E_QUAL    = 3'd3;
  localparam logic [2:0] E_SHORT   = 3'd4;
  localparam logic [2:0] E_SIZE    = 3'd5;
  localparam logic [2:0] E_TIMEOUT = 3'd6;

  localparam logic [8:0] LAT9       = 9'(CHECK_LAT);
  localparam logic [8:0] TO9        = 9'(TIMEOUT_CYC);
  localparam logic [7:0] SKIP_N     = 8'(SKIP_FIRST);
  localparam bit         TIMEOUT_EN = (TIMEOUT_CYC > CHECK_LAT);

  state_t      state, state_nxt;
  logic [2:0]  err_nxt;
  logic [2:0]  size_q;
  logic [8:0]  bit_cnt;
  logic [8:0]  bit_nxt;
  logic [4:0]  word_cnt;
  logic [7:0]  skip_cnt;
  logic        crc_seen;
  logic        q_seen;
  logic        ovf;
  logic        ed_seen;
  logic        armed;
  logic [8:0]  exp_bits;
  logic [4:0]  exp_words;
  logic        size_legal;
  logic        ed_late_ok;
  logic        lat_hit;
  logic        to_hit;
  logic        past_lat;

  always_comb begin
    exp_bits  = 9'd24;
    exp_words = 5'd1;
    case (size_q)
      3'd0: begin exp_bits = 9'd24;  exp_words = 5'd1;  end
      3'd1: begin exp_bits = 9'd40;  exp_words = 5'd2;  end
      3'd2: begin exp_bits = 9'd72;  exp_words = 5'd4;  end
      3'd3: begin exp_bits = 9'd144; exp_words = 5'd8;  end
      3'd4: begin exp_bits = 9'd288; exp_words = 5'd16; end
      default: begin exp_bits = 9'd24; exp_words = 5'd1; end
    endcase
  end

  assign size_legal = (size_sel <= 3'd4);
  assign bit_nxt    = bit_cnt + 9'd1;
  // Window ends are compared against the incremented count so the move happens as the counter lands on them.
  assign lat_hit    = (bit_nxt == exp_bits + LAT9);
  assign to_hit     = (bit_nxt == exp_bits + TO9);
  assign past_lat   = (bit_cnt >= exp_bits + LAT9);
  assign ed_late_ok = ed_seen || (ed_detect && bit_cnt >= exp_bits);

  always_ff @(posedge clk_3M) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    case (state)
      S_IDLE: begin
        if (sd_detect) begin
          if (size_legal) begin
            state_nxt = S_RECV;
            err_nxt   = E_NONE;
          end else begin
            state_nxt = S_ERR;
            err_nxt   = E_SIZE;
          end
        end
      end
      S_RECV: begin
        if (ed_detect && bit_cnt < exp_bits) begin
          state_nxt = S_ERR;
          err_nxt   = E_SHORT;
        end else if (lat_hit && (ed_late_ok || !TIMEOUT_EN)) begin
          state_nxt = S_CHECK;
        end else if (TIMEOUT_EN && ed_detect && past_lat) begin
          state_nxt = S_CHECK;
        end else if (TIMEOUT_EN && to_hit && !ed_late_ok) begin
          state_nxt = S_ERR;
          err_nxt   = E_TIMEOUT;
        end
      end
      S_CHECK: begin
        if (crc_seen) begin
          state_nxt = S_ERR;
          err_nxt   = E_CRC;
        end else if (q_seen) begin
          state_nxt = S_ERR;
          err_nxt   = E_QUAL;
        end else if (word_cnt != exp_words || ovf) begin
          state_nxt = S_ERR;
          err_nxt   = E_LEN;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // rx_word_valid is a one-cycle strobe with no backpressure: rx_word and rx_word_idx are valid only while it is high.
  always_ff @(posedge clk_3M) begin
    if (!rst) begin
      size_q        <= 3'd0;
      bit_cnt       <= 9'd0;
      word_cnt      <= 5'd0;
      skip_cnt      <= 8'd0;
      crc_seen      <= 1'b0;
      q_seen        <= 1'b0;
      ovf           <= 1'b0;
      ed_seen       <= 1'b0;
      armed         <= 1'b0;
      err_code      <= E_NONE;
      rx_word       <= 16'd0;
      rx_word_valid <= 1'b0;
      rx_word_idx   <= 4'd0;
    end else begin
      err_code      <= err_nxt;
      rx_word_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sd_detect && size_legal) begin
            size_q   <= size_sel;
            bit_cnt  <= 9'd0;
            word_cnt <= 5'd0;
            skip_cnt <= 8'd0;
            crc_seen <= 1'b0;
            q_seen   <= 1'b0;
            ovf      <= 1'b0;
            ed_seen  <= 1'b0;
            armed    <= 1'b1;
          end
        end
        S_RECV: begin
          bit_cnt <= bit_nxt;
          if (word_valid) begin
            if (skip_cnt < SKIP_N) begin
              skip_cnt <= skip_cnt + 8'd1;
            end else if (word_cnt < exp_words) begin
              rx_word       <= word_data;
              rx_word_idx   <= word_cnt[3:0];
              rx_word_valid <= 1'b1;
              word_cnt      <= word_cnt + 5'd1;
            end else begin
              ovf <= 1'b1;
            end
          end
          if (crc_error)     crc_seen <= 1'b1;
          if (quality_error) q_seen   <= 1'b1;
          if (ed_detect && bit_cnt >= exp_bits) ed_seen <= 1'b1;
        end
        S_DONE, S_ERR: armed <= 1'b0;
        default: ;
      endcase
    end
  end

  // The deserializer runs from the first RECV cycle until the verdict cycle; it is held in reset otherwise.
  assign des_rst_n  = armed;
  assign busy       = armed;
  assign frame_done = (state == S_DONE);
  assign frame_err  = (state == S_ERR);

`ifdef MVB_RX_STATS_EN
  always_ff @(posedge clk_3M) begin
    if (!rst) begin
      good_cnt <= 16'd0;
      bad_cnt  <= 16'd0;
    end else begin
      if (frame_done && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      if (frame_err && bad_cnt != 16'hFFFF)   bad_cnt  <= bad_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mvb_rx_frame_ctrl.sv
// Scoreboard bench for mvb_rx_frame_ctrl: expected words and frame verdicts are queued as stimulus is driven and popped as the DUT reports them.
`timescale 1ns/1ps
module tb_mvb_rx_frame_ctrl;
  localparam int TIMEOUT_CYC = 16;

  // clock / reset
  logic        clk_3M = 1'b0;
  logic        rst = 1'b0;
  logic        sd_detect = 1'b0;
  logic        ed_detect = 1'b0;
  logic [2:0]  size_sel = 3'd0;
  logic        word_valid = 1'b0;
  logic [15:0] word_data = 16'd0;
  logic        crc_error = 1'b0;
  logic        quality_error = 1'b0;
  logic        des_rst_n;
  logic [15:0] rx_word;
  logic        rx_word_valid;
  logic [3:0]  rx_word_idx;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  err_code;
  logic        busy;
`ifdef MVB_RX_STATS_EN
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
`endif

  always #10 clk_3M = ~clk_3M;

  mvb_rx_frame_ctrl dut (
    .clk_3M        (clk_3M),
    .rst           (rst),
    .sd_detect     (sd_detect),
    .ed_detect     (ed_detect),
    .size_sel      (size_sel),
    .word_valid    (word_valid),
    .word_data     (word_data),
    .crc_error     (crc_error),
    .quality_error (quality_error),
    .des_rst_n     (des_rst_n),
    .rx_word       (rx_word),
    .rx_word_valid (rx_word_valid),
    .rx_word_idx   (rx_word_idx),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .busy          (busy)
`ifdef MVB_RX_STATS_EN
    ,
    .good_cnt      (good_cnt),
    .bad_cnt       (bad_cnt)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int e0_cyc = 0;
  int last_done_cyc = 0;
  logic busy_seen = 1'b0;
  logic post_chk = 1'b0;
  logic [19:0] exp_q[$];
  logic [3:0]  exp_f[$];
  logic [19:0] ew_item;
  logic [3:0]  ef_item;

  always @(posedge clk_3M) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic int bits_of(input logic [2:0] sz);
    case (sz)
      3'd0: return 24;
      3'd1: return 40;
      3'd2: return 72;
      3'd3: return 144;
      3'd4: return 288;
      default: return 0;
    endcase
  endfunction

  function automatic int words_of(input logic [2:0] sz);
    case (sz)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd3: return 8;
      3'd4: return 16;
      default: return 0;
    endcase
  endfunction

  task automatic chk_reset(input string p);
    check_eq({p, "_des_rst_n"}, des_rst_n, 0);
    check_eq({p, "_rx_word"}, rx_word, 0);
    check_eq({p, "_rx_valid"}, rx_word_valid, 0);
    check_eq({p, "_rx_idx"}, rx_word_idx, 0);
    check_eq({p, "_done"}, frame_done, 0);
    check_eq({p, "_err"}, frame_err, 0);
    check_eq({p, "_err_code"}, err_code, 0);
    check_eq({p, "_busy"}, busy, 0);
  endtask

  // scoreboard: words and frame verdicts
  always @(negedge clk_3M) begin
    if (busy) busy_seen = 1'b1;
    if (post_chk) begin
      check_eq("des_rst_after_end", des_rst_n, 0);
      post_chk = 1'b0;
    end
    if (rx_word_valid) begin
      if (exp_q.size() == 0) check_eq("word_extra", exp_q.size(), 1);
      else begin
        ew_item = exp_q.pop_front();
        check_eq("word_idx", rx_word_idx, ew_item[19:16]);
        check_eq("word_data", rx_word, ew_item[15:0]);
      end
    end
    if (frame_done || frame_err) begin
      check_eq("done_err_excl", frame_done & frame_err, 0);
      if (exp_f.size() == 0) check_eq("frame_extra", exp_f.size(), 1);
      else begin
        ef_item = exp_f.pop_front();
        check_eq("frame_kind", frame_err, ef_item[3]);
        check_eq("frame_code", err_code, ef_item[2:0]);
      end
      post_chk = 1'b1;
      if (frame_done) last_done_cyc = cyc;
    end
  end

  // driver: n_words strobes (the first is the startup word) every other bit from bit 2
  task automatic send_frame(input logic [2:0] sz, input int n_words, input logic [15:0] base,
                            input int ed_at, input int crc_at, input int q_at, input int rst_at);
    int eb;
    int ew;
    int len;
    int j;
    logic [15:0] d;
    eb  = bits_of(sz);
    ew  = words_of(sz);
    len = (sz <= 3'd4) ? eb + TIMEOUT_CYC + 4 : 4;
    @(posedge clk_3M); #1;
    sd_detect = 1'b1;
    size_sel  = sz;
    @(posedge clk_3M); #1;
    sd_detect = 1'b0;
    e0_cyc    = cyc;
    for (int k = 0; k < len; k++) begin
      word_valid    = 1'b0;
      ed_detect     = (k == ed_at);
      crc_error     = (k == crc_at);
      quality_error = (k == q_at);
      j = k / 2 - 1;
      if (k >= 2 && (k % 2) == 0 && j < n_words) begin
        d = (j == 0) ? 16'hDEAD : base + 16'(j - 1);
        word_valid = 1'b1;
        word_data  = d;
        if (j >= 1 && (j - 1) < ew) exp_q.push_back({4'(j - 1), d});
      end
      if (k == rst_at) rst = 1'b0;
      @(posedge clk_3M); #1;
      if (k == rst_at) begin
        chk_reset("midrst");
        rst = 1'b1;
      end
    end
    word_valid    = 1'b0;
    ed_detect     = 1'b0;
    crc_error     = 1'b0;
    quality_error = 1'b0;
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk_3M);
    #1;
    chk_reset("por");
    rst = 1'b1;

    // single word frame, done 28 cycles after RECV entry
    exp_f.push_back({1'b0, 3'd0});
    send_frame(3'd0, 2, 16'hA5C3, 24, -1, -1, -1);
    check_eq("t1_done_lat", last_done_cyc - e0_cyc, 28);
    check_eq("t1_err_code_held", err_code, 0);

    // max size, idx 0..15
    exp_f.push_back({1'b0, 3'd0});
    send_frame(3'd4, 17, 16'h0000, 288, -1, -1, -1);

    // late crc pulse inside the collection window
    exp_f.push_back({1'b1, 3'd1});
    send_frame(3'd2, 5, 16'h1000, 72, 73, -1, -1);

    // short frame
    exp_f.push_back({1'b1, 3'd4});
    send_frame(3'd1, 3, 16'h2000, 20, -1, -1, -1);
    check_eq("t4_err_code_held", err_code, 4);

    // illegal size
    busy_seen = 1'b0;
    exp_f.push_back({1'b1, 3'd5});
    send_frame(3'd6, 0, 16'h0, -1, -1, -1, -1);
    check_eq("t5_busy_never", busy_seen, 0);

    // quality violation
    exp_f.push_back({1'b1, 3'd3});
    send_frame(3'd1, 3, 16'h3000, 40, -1, 30, -1);

    // extra word -> overflow length error
    exp_f.push_back({1'b1, 3'd2});
    send_frame(3'd0, 3, 16'h4000, 24, -1, -1, -1);

    // missing end delimiter
    exp_f.push_back({1'b1, 3'd6});
    send_frame(3'd0, 2, 16'h5000, -1, -1, -1, -1);

    // reset mid-frame, then a clean frame
    send_frame(3'd3, 9, 16'h6000, -1, -1, -1, 50);
    exp_f.push_back({1'b0, 3'd0});
    send_frame(3'd0, 2, 16'h1234, 24, -1, -1, -1);

    repeat (5) @(posedge clk_3M);
    #1;
    check_eq("words_left", exp_q.size(), 0);
    check_eq("frames_left", exp_f.size(), 0);
`ifdef MVB_RX_STATS_EN
    check_eq("good_cnt", good_cnt, 3);
    check_eq("bad_cnt", bad_cnt, 6);
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
